toggle_period_meter: RTL and testbench
======================================

Name: toggle_period_meter

Overview:
Downstream consumer of the T flip-flop's q output. Samples q, detects rising and falling edges, and measures two values per cycle of q, both in clk cycles: the full period (rising edge to rising edge) and the high time. Results go out through a valid/ack handshake. Sticky status flags report timeout (q stalled) and overrun (result not consumed in time).

Parameters:
CNT_W, 16, width of period/high_time counters and outputs
TIMEOUT, 1000, cycles after a rising edge with no next rising edge before timeout fires; must satisfy 2 <= TIMEOUT <= 2^CNT_W-1

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
q_in  input  1  toggle output of upstream T flip-flop, synchronous to clk (no synchronizer)
enable  input  1  1 = measure; 0 = return to IDLE, clear sticky flags
period  output  CNT_W  last accepted period in clk cycles
high_time  output  CNT_W  last accepted high time in clk cycles
period_valid  output  1  result available; held until acked
period_ack  input  1  consumer accepts result when period_valid=1
timeout  output  1  sticky: no rising edge within TIMEOUT cycles
overrun  output  1  sticky: a completed measurement was dropped because period_valid was still pending

Behaviour:
- Reset (sync, active-high, dominates all inputs): state=IDLE, q_d=0, cnt=0, hi_cnt=0, period=0, high_time=0, period_valid=0, timeout=0, overrun=0.
- q_d <= q_in every cycle, in every state except reset. rise = q_in & ~q_d (combinational).
- States: IDLE, ARM, MEASURE.
- IDLE: counters held at 0. enable=1 -> ARM next cycle. No rise detection acts in IDLE.
- ARM: wait for rise. On rise: cnt<=1, hi_cnt<=1, go to MEASURE. If q_in is already high when ARM is entered, wait for the next true rise.
- MEASURE, no rise this cycle: cnt<=cnt+1; hi_cnt<=hi_cnt+q_in.
- MEASURE, rise this cycle: the measurement is complete. Restart with cnt<=1, hi_cnt<=1, stay in MEASURE.
  - If period_valid=0, or period_ack=1 this cycle: period<=cnt, high_time<=hi_cnt, period_valid<=1.
  - Otherwise (pending, not acked): drop the new result; old result is held; overrun<=1.
- Timeout: in MEASURE, with cnt==TIMEOUT and no rise: timeout<=1, counters cleared, state -> ARM. cnt never exceeds TIMEOUT, so no wrap is possible.
- Handshake: period_valid=1 and period_ack=1 with no new result that cycle -> period_valid<=0 next cycle. Ack while period_valid=0 is ignored. period/high_time are stable while period_valid=1.
- enable=0 in any state: state->IDLE next cycle, cnt/hi_cnt<=0, timeout<=0, overrun<=0. period, high_time and period_valid are untouched, so a pending result survives and can still be acked.
- Latency: a result is visible on the clock edge that samples the completing rise, i.e. 1 cycle after q_in goes high.
- Reset mid-measurement: all state is lost, including pending results; no partial result is emitted.

Test Plan:
- Reset high 2 cycles, then enable=1, q_in toggling every cycle (upstream T=1 constantly) -> first result period=2, high_time=1, period_valid=1; same values repeat on each ack.
- q_in pattern high 3 / low 5 repeated, ack each result 1 cycle after valid -> period=8, high_time=3, overrun=0, timeout=0.
- TIMEOUT=20; one rise, then q_in held high -> timeout=1 exactly 20 cycles after the rise edge, state ARM, period_valid unchanged; next valid rise resumes measurement.
- Pattern high 2 / low 2 with no ack -> first result (4,2) held; overrun=1 on the second rise. Then ack in the same cycle as the third rise -> result reloaded (4,2), period_valid stays 1.
- Reset pulse asserted mid-MEASURE with period_valid=1 -> next cycle all outputs 0, state IDLE; remains IDLE until enable is seen after reset.
- enable dropped with a result pending and timeout=1 -> timeout=0 next cycle, period_valid still 1; a subsequent ack clears it.

Source files
------------

// File: rtl/toggle_period_meter.sv
// Measures period and high time of a toggling input in clk cycles and
// hands each result to a consumer through a valid/ack handshake.
module toggle_period_meter #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             q_in,
   input  logic             enable,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   input  logic             period_ack,
   output logic             timeout,
   output logic             overrun
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state_q;
   logic             q_dly_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] hi_cnt_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] high_time_q;
   logic             valid_q;
   logic             timeout_q;
   logic             overrun_q;
   logic             rise;

   assign rise = q_in & ~q_dly_q;

   // Measurement FSM, counters, result registers and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         q_dly_q     <= 1'b0;
         cnt_q       <= CNT_ZERO;
         hi_cnt_q    <= CNT_ZERO;
         period_q    <= CNT_ZERO;
         high_time_q <= CNT_ZERO;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         q_dly_q <= q_in;
         // An ack retires the pending result unless a new one is loaded below
         if (valid_q && period_ack) begin
            valid_q <= 1'b0;
         end
         if (!enable) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            hi_cnt_q  <= CNT_ZERO;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  cnt_q    <= CNT_ZERO;
                  hi_cnt_q <= CNT_ZERO;
                  state_q  <= ST_ARM;
               end
               ST_ARM: begin
                  if (rise) begin
                     cnt_q    <= CNT_ONE;
                     hi_cnt_q <= CNT_ONE;
                     state_q  <= ST_MEASURE;
                  end else begin
                     cnt_q    <= CNT_ZERO;
                     hi_cnt_q <= CNT_ZERO;
                  end
               end
               ST_MEASURE: begin
                  if (rise) begin
                     cnt_q    <= CNT_ONE;
                     hi_cnt_q <= CNT_ONE;
                     if (!valid_q || period_ack) begin
                        period_q    <= cnt_q;
                        high_time_q <= hi_cnt_q;
                        valid_q     <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end else if (cnt_q == TIMEOUT_C) begin
                     timeout_q <= 1'b1;
                     cnt_q     <= CNT_ZERO;
                     hi_cnt_q  <= CNT_ZERO;
                     state_q   <= ST_ARM;
                  end else begin
                     cnt_q    <= cnt_q + CNT_ONE;
                     hi_cnt_q <= hi_cnt_q + CNT_W'(q_in);
                  end
               end
               default: begin
                  state_q  <= ST_IDLE;
                  cnt_q    <= CNT_ZERO;
                  hi_cnt_q <= CNT_ZERO;
               end
            endcase
         end
      end
   end

   assign period       = period_q;
   assign high_time    = high_time_q;
   assign period_valid = valid_q;
   assign timeout      = timeout_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_toggle_period_meter.sv
// Randomised and directed bench for toggle_period_meter against a
// rise-timestamp reference model.
module tb_toggle_period_meter;

   localparam int CNT_W = 16;
   localparam int TO    = 20;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             q_in = 1'b0;
   logic             enable = 1'b0;
   logic             period_ack = 1'b0;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             period_valid;
   logic             timeout;
   logic             overrun;

   int n_pass  = 0;
   int n_total = 0;

   // reference model: timestamps of rises and a history of sampled q
   int               cyc = 0;
   bit               hist [4096];
   bit               m_qp = 1'b0;
   int               m_mode = 0;   // 0 idle, 1 waiting for rise, 2 measuring
   int               m_start = 0;
   logic [CNT_W-1:0] m_period = '0;
   logic [CNT_W-1:0] m_high = '0;
   bit               m_valid = 1'b0;
   bit               m_to = 1'b0;
   bit               m_ov = 1'b0;

   toggle_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .q_in         (q_in),
      .enable       (enable),
      .period       (period),
      .high_time    (high_time),
      .period_valid (period_valid),
      .period_ack   (period_ack),
      .timeout      (timeout),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   // drive one cycle of inputs, advance the model, and return 1 time unit after the edge
   task automatic step(input bit r, input bit q, input bit en, input bit ack);
      bit rise;
      bit old_v;
      bit load;
      int hsum;
      reset = r; q_in = q; enable = en; period_ack = ack;
      load = 1'b0;
      if (r) begin
         m_mode = 0; m_qp = 1'b0; m_period = '0; m_high = '0;
         m_valid = 1'b0; m_to = 1'b0; m_ov = 1'b0;
      end else begin
         rise  = q && !m_qp;
         old_v = m_valid;
         hist[cyc % 4096] = q;
         m_qp = q;
         if (!en) begin
            m_mode = 0; m_to = 1'b0; m_ov = 1'b0;
         end else if (m_mode == 0) begin
            m_mode = 1;
         end else if (m_mode == 1) begin
            if (rise) begin
               m_start = cyc; m_mode = 2;
            end
         end else begin
            if (rise) begin
               if (!old_v || ack) begin
                  hsum = 0;
                  for (int i = m_start; i < cyc; i++) hsum += int'(hist[i % 4096]);
                  m_period = CNT_W'(cyc - m_start);
                  m_high   = CNT_W'(hsum);
                  load = 1'b1;
               end else begin
                  m_ov = 1'b1;
               end
               m_start = cyc;
            end else if (cyc - m_start == TO) begin
               m_to = 1'b1; m_mode = 1;
            end
         end
         if (old_v && ack) m_valid = 1'b0;
         if (load) m_valid = 1'b1;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n_total++;
      if ({period, high_time, period_valid, timeout, overrun} !== 35'd0) begin
         $display("FAIL reset_outputs: got p=%0d h=%0d v=%0b t=%0b o=%0b want all 0",
                  period, high_time, period_valid, timeout, overrun);
      end else n_pass++;
   endtask

   task automatic test_toggle();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      n_total++;
      if (period !== 16'd2 || high_time !== 16'd1 || period_valid !== 1'b1) begin
         $display("FAIL toggle_first: got p=%0d h=%0d v=%0b want p=2 h=1 v=1",
                  period, high_time, period_valid);
      end else n_pass++;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, bit'(i % 2), 1'b1, 1'b1);
         n_total++;
         if (period_valid !== m_valid || (m_valid && (period !== 16'd2 || high_time !== 16'd1))) begin
            $display("FAIL toggle_ack[%0d]: got p=%0d h=%0d v=%0b want p=2 h=1 v=%0b",
                     i, period, high_time, period_valid, m_valid);
         end else n_pass++;
      end
   endtask

   task automatic test_pattern_3_5();
      for (int r = 0; r < 4; r++) begin
         for (int j = 0; j < 8; j++) begin
            step(1'b0, j < 3, 1'b1, m_valid);
            n_total++;
            if (period !== m_period || high_time !== m_high || period_valid !== m_valid ||
                overrun !== m_ov || timeout !== m_to) begin
               $display("FAIL pattern35[%0d.%0d]: got p=%0d h=%0d v=%0b o=%0b t=%0b want p=%0d h=%0d v=%0b o=%0b t=%0b",
                        r, j, period, high_time, period_valid, overrun, timeout,
                        m_period, m_high, m_valid, m_ov, m_to);
            end else n_pass++;
         end
      end
      n_total++;
      if (period !== 16'd8 || high_time !== 16'd3 || overrun !== 1'b0 || timeout !== 1'b0) begin
         $display("FAIL pattern35_final: got p=%0d h=%0d o=%0b t=%0b want p=8 h=3 o=0 t=0",
                  period, high_time, overrun, timeout);
      end else n_pass++;
   endtask

   task automatic test_timeout();
      step(1'b0, 1'b1, 1'b1, m_valid);
      for (int k = 1; k <= 22; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0);
         n_total++;
         if (timeout !== (k >= TO) || period_valid !== 1'b1) begin
            $display("FAIL timeout[%0d]: got t=%0b v=%0b want t=%0b v=1",
                     k, timeout, period_valid, (k >= TO));
         end else n_pass++;
      end
      // resume: a new rise re-arms, the next one completes with a fresh result
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      n_total++;
      if (period !== 16'd3 || high_time !== 16'd1 || period_valid !== 1'b1 || timeout !== 1'b1) begin
         $display("FAIL timeout_resume: got p=%0d h=%0d v=%0b t=%0b want p=3 h=1 v=1 t=1",
                  period, high_time, period_valid, timeout);
      end else n_pass++;
   endtask

   task automatic test_enable_drop();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (timeout !== 1'b0 || period_valid !== 1'b1 || period !== 16'd3) begin
         $display("FAIL enable_drop: got t=%0b v=%0b p=%0d want t=0 v=1 p=3",
                  timeout, period_valid, period);
      end else n_pass++;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n_total++;
      if (period_valid !== 1'b0) begin
         $display("FAIL enable_drop_ack: got v=%0b want v=0", period_valid);
      end else n_pass++;
   endtask

   task automatic test_overrun();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int rep = 0; rep < 4; rep++) begin
         step(1'b0, 1'b1, 1'b1, rep == 3);
         n_total++;
         if (rep >= 1 && (period !== 16'd4 || high_time !== 16'd2 || period_valid !== 1'b1 ||
                          overrun !== (rep >= 2))) begin
            $display("FAIL overrun[%0d]: got p=%0d h=%0d v=%0b o=%0b want p=4 h=2 v=1 o=%0b",
                     rep, period, high_time, period_valid, overrun, (rep >= 2));
         end else if (rep == 0 && (period_valid !== 1'b0 || overrun !== 1'b0)) begin
            $display("FAIL overrun_arm: got v=%0b o=%0b want v=0 o=0", period_valid, overrun);
         end else n_pass++;
         step(1'b0, 1'b1, 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b1, 1'b1, 1'b0);
      n_total++;
      if ({period, high_time, period_valid, timeout, overrun} !== 35'd0) begin
         $display("FAIL reset_mid: got p=%0d h=%0d v=%0b t=%0b o=%0b want all 0",
                  period, high_time, period_valid, timeout, overrun);
      end else n_pass++;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, bit'(i % 2), 1'b0, 1'b0);
         n_total++;
         if (period_valid !== 1'b0 || period !== 16'd0) begin
            $display("FAIL reset_idle[%0d]: got v=%0b p=%0d want v=0 p=0", i, period_valid, period);
         end else n_pass++;
      end
   endtask

   task automatic test_random();
      bit q_cur = 1'b0;
      int run_left = 1;
      bit en;
      bit rst;
      for (int i = 0; i < 1500; i++) begin
         run_left--;
         if (run_left <= 0) begin
            q_cur = ~q_cur;
            run_left = ($urandom_range(0, 9) == 0) ? $urandom_range(22, 30) : $urandom_range(1, 10);
         end
         rst = ($urandom_range(0, 299) == 0);
         en  = ($urandom_range(0, 59) != 0);
         step(rst, q_cur, en, bit'($urandom_range(0, 1)));
         n_total++;
         if (period !== m_period || high_time !== m_high || period_valid !== m_valid ||
             overrun !== m_ov || timeout !== m_to) begin
            $display("FAIL random[%0d]: got p=%0d h=%0d v=%0b o=%0b t=%0b want p=%0d h=%0d v=%0b o=%0b t=%0b",
                     i, period, high_time, period_valid, overrun, timeout,
                     m_period, m_high, m_valid, m_ov, m_to);
         end else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_toggle();
      test_pattern_3_5();
      test_timeout();
      test_enable_drop();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
